mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency backing memory between the instruction-fetch port (IF stage) and the data-memory port (MEM stage) of the 5-stage pipeline.
- Arbitrates between the two ports, sequences each access with a req/ack handshake, and returns read data with a one-cycle ready pulse.
- Drives a stall to the hazard logic while any port is waiting, so the pipeline freezes until its access completes.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 64, maximum cycles in a BUSY state without mem_ack_i before the access is aborted

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request (level)
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetched instruction, valid when if_ready_o=1
- if_ready_o  out  1  one-cycle fetch-complete pulse
- dm_read_i  in  1  data read request (level)
- dm_write_i  in  1  data write request (level)
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data, valid when dm_ready_o=1
- dm_ready_o  out  1  one-cycle data-complete pulse
- mem_req_o  out  1  backing-memory request
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  ADDR_W  backing-memory address
- mem_wdata_o  out  DATA_W  backing-memory write data
- mem_rdata_i  in  DATA_W  backing-memory read data, valid with mem_ack_i
- mem_ack_i  in  1  backing-memory completion, one cycle
- stall_o  out  1  pipeline stall
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, last_grant=IF, timeout counter=0.
  - All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_data_o, dm_rdata_o, ready pulses, err_o.
  - stall_o follows its equation below and so reflects pending requests only.
  - Reset mid-access abandons the access. An ack arriving after reset is ignored.
- Requests:
  - dm_req = dm_read_i | dm_write_i.
  - Requesters hold request, address and wdata stable until they sample their ready pulse.
  - dm_read_i and dm_write_i both high is treated as a write.
- States: IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM.
- IDLE:
  - Only if_req_i -> BUSY_IF. Only dm_req -> BUSY_DM.
  - Both -> grant the port opposite to last_grant.
  - Neither -> stay in IDLE.
  - On the granting edge, register mem_addr_o, mem_wdata_o and mem_we_o (we=dm_write_i for DM, 0 for IF). Set mem_req_o=1. Clear the timeout counter.
- BUSY_x:
  - mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o are held constant.
  - mem_ack_i=1 -> latch mem_rdata_i into if_data_o or dm_rdata_o. Drop mem_req_o. Go to RESP_x. Set last_grant=x.
  - No ack -> increment the counter. When the counter reaches TIMEOUT-1 with no ack: drop mem_req_o, latch 0 as read data, set err_o=1 (held until reset), go to RESP_x.
- RESP_x:
  - x_ready_o=1 for exactly this cycle.
  - The request from x is still asserted but is ignored for arbitration.
  - If the other port is requesting -> go directly to BUSY_other, with the same register actions as the IDLE grant. Otherwise -> IDLE.
- Read-data outputs hold their last latched value until the next completion for that port.
- Latency:
  - Request seen in cycle 0 -> mem_req_o=1 in cycle 1.
  - Ack in cycle k (k≥1) -> ready pulse in cycle k+1.
  - Minimum request-to-ready time is 2 cycles.
- stall_o, combinational: (if_req_i & ~if_ready_o) | (dm_req & ~dm_ready_o).
- Writes return dm_ready_o. dm_rdata_o is updated from mem_rdata_i and is don't-care for the requester.
- mem_ack_i outside BUSY states is ignored.
- Addresses and data pass through at full width. There is no alignment checking.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=0x0000_0010; memory acks 1 cycle after mem_req_o with 0x0050_0093.
  - Expect mem_req_o=1, mem_we_o=0, mem_addr_o=0x10 in cycle 1.
  - Expect if_ready_o pulse in cycle 2 with if_data_o=0x0050_0093.
  - Expect stall_o=1 in cycles 0–1 and 0 in cycle 2.
- Simultaneous requests after reset: fetch 0x20 and read 0x100.
  - DM is granted first (last_grant=IF).
  - From RESP_DM the arbiter goes straight to BUSY_IF, so mem_addr_o=0x20 in the cycle after dm_ready_o.
- Write: dm_write_i=1, addr 0x8, wdata 0xCAFE_F00D, ack delayed 5 cycles.
  - Expect mem_we_o=1 and mem_wdata_o=0xCAFE_F00D held constant throughout.
  - Expect a single dm_ready_o pulse.
  - Expect stall_o=1 until that pulse.
- Alternation: both ports requesting continuously, 1-cycle acks.
  - Grants alternate DM, IF, DM, IF.
  - No port is granted twice in a row while the other is pending.
- Timeout: fetch with mem_ack_i held at 0.
  - After 64 BUSY cycles: mem_req_o falls, if_ready_o pulses with if_data_o=0, err_o=1 and stays 1.
- Reset mid-access: assert rst_i=0 during BUSY_DM, then deassert it and pulse mem_ack_i.
  - mem_req_o=0 immediately on reset.
  - No ready pulse, state IDLE, err_o=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency backing memory
// between the instruction-fetch port and the data-memory port. It alternates
// grants under contention, returns read data with a one-cycle ready pulse,
// aborts accesses that never get an ack, and stalls the pipeline while a
// port waits.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP_IF,
    RESP_DM
  } state_e;

  state_e            state_q;
  logic              lastGrantDm_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              memReq_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic [DATA_W-1:0] ifData_q;
  logic [DATA_W-1:0] dmData_q;
  logic              ifReady_q;
  logic              dmReady_q;
  logic              err_q;

  logic              dmReq;
  logic              grantIf;
  logic              grantDm;

  // A simultaneous read and write request is handled as a write.
  assign dmReq = dm_read_i | dm_write_i;

  assign if_data_o   = ifData_q;
  assign if_ready_o  = ifReady_q;
  assign dm_rdata_o  = dmData_q;
  assign dm_ready_o  = dmReady_q;
  assign mem_req_o   = memReq_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign err_o       = err_q;

  // The stall follows the raw requests so it is visible even during reset.
  assign stall_o = (if_req_i & ~ifReady_q) | (dmReq & ~dmReady_q);

  assign cnt_d = cnt_q + CNT_W'(1);

  // Grant decision: in a response cycle only the other port may win, and a
  // tie in IDLE goes to the port that did not complete last.
  always_comb begin
    grantIf = 1'b0;
    grantDm = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i && dmReq) begin
          grantIf = lastGrantDm_q;
          grantDm = ~lastGrantDm_q;
        end else begin
          grantIf = if_req_i;
          grantDm = dmReq;
        end
      end
      RESP_IF: grantDm = dmReq;
      RESP_DM: grantIf = if_req_i;
      default: begin
        grantIf = 1'b0;
        grantDm = 1'b0;
      end
    endcase
  end

  // Access sequencer: grants, holds the memory request, completes on ack or
  // timeout, and produces the registered ready pulses and read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      lastGrantDm_q <= 1'b0;
      cnt_q         <= '0;
      memReq_q      <= 1'b0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      ifData_q      <= '0;
      dmData_q      <= '0;
      ifReady_q     <= 1'b0;
      dmReady_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ifReady_q <= 1'b0;
      dmReady_q <= 1'b0;
      case (state_q)
        IDLE, RESP_IF, RESP_DM: begin
          if (grantIf) begin
            state_q    <= BUSY_IF;
            memReq_q   <= 1'b1;
            memWe_q    <= 1'b0;
            memAddr_q  <= if_addr_i;
            memWdata_q <= '0;
            cnt_q      <= '0;
          end else if (grantDm) begin
            state_q    <= BUSY_DM;
            memReq_q   <= 1'b1;
            memWe_q    <= dm_write_i;
            memAddr_q  <= dm_addr_i;
            memWdata_q <= dm_wdata_i;
            cnt_q      <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY_IF: begin
          if (mem_ack_i) begin
            ifData_q      <= mem_rdata_i;
            memReq_q      <= 1'b0;
            ifReady_q     <= 1'b1;
            lastGrantDm_q <= 1'b0;
            state_q       <= RESP_IF;
          end else if (cnt_q == CNT_LAST) begin
            ifData_q  <= '0;
            memReq_q  <= 1'b0;
            ifReady_q <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= RESP_IF;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        BUSY_DM: begin
          if (mem_ack_i) begin
            dmData_q      <= mem_rdata_i;
            memReq_q      <= 1'b0;
            dmReady_q     <= 1'b1;
            lastGrantDm_q <= 1'b1;
            state_q       <= RESP_DM;
          end else if (cnt_q == CNT_LAST) begin
            dmData_q  <= '0;
            memReq_q  <= 1'b0;
            dmReady_q <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= RESP_DM;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives both requester ports and a backing memory with
// randomized and directed traffic and compares every cycle against a
// transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ready_o;
  logic              dm_read_i = 1'b0;
  logic              dm_write_i = 1'b0;
  logic [ADDR_W-1:0] dm_addr_i = '0;
  logic [DATA_W-1:0] dm_wdata_i = '0;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ready_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mem_ack_i = 1'b0;
  logic              stall_o;
  logic              err_o;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_ready_o (if_ready_o),
    .dm_read_i  (dm_read_i),
    .dm_write_i (dm_write_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_rdata_o (dm_rdata_o),
    .dm_ready_o (dm_ready_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i),
    .stall_o    (stall_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: which port owns the memory (0 none, 1 IF, 2 DM), which
  // port completes in the current cycle, who completed last, and the data
  // each port should be showing.
  int          mOwner;
  int          mResp;
  int          mLast;
  int          mCnt;
  int unsigned memCnt;
  logic        mErr;
  logic [31:0] mIfData;
  logic [31:0] mDmData;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic        mWe;

  // Stimulus controls.
  bit          autoReq = 0;
  int unsigned reqRate = 0;
  int unsigned dlyLo = 0;
  int unsigned dlyHi = 0;
  bit          noAck = 0;
  bit          spurious = 0;
  bit          forceData = 0;
  bit          forceAckOnce = 0;
  logic [31:0] forcedData = '0;

  // Requester state.
  bit          ifPend = 0;
  bit          ifDrop = 0;
  logic [31:0] ifAddr = '0;
  bit          dmPend = 0;
  bit          dmDrop = 0;
  bit          dmRd = 0;
  bit          dmWr = 0;
  logic [31:0] dmAddr = '0;
  logic [31:0] dmWdata = '0;

  // Count one comparison and report it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mOwner  = 0;
    mResp   = 0;
    mLast   = 1;
    mCnt    = 0;
    memCnt  = 0;
    mErr    = 1'b0;
    mIfData = '0;
    mDmData = '0;
    mAddr   = '0;
    mWdata  = '0;
    mWe     = 1'b0;
  endtask

  // One clock cycle: check registered outputs, choose inputs, check the
  // stall, then advance the reference model across the coming edge.
  task automatic applyStimulus();
    bit          ack;
    bit          started;
    bit          eIf;
    bit          eDm;
    int          pick;
    int          newResp;
    int unsigned op;
    logic [31:0] rd;

    @(negedge clk_i);
    checkOutput("mem_req", 32'(mem_req_o), 32'(mOwner != 0));
    if (mOwner != 0) begin
      checkOutput("mem_addr", mem_addr_o, mAddr);
      checkOutput("mem_we", 32'(mem_we_o), 32'(mWe));
      if (mOwner == 2) checkOutput("mem_wdata", mem_wdata_o, mWdata);
    end
    checkOutput("if_ready", 32'(if_ready_o), 32'(mResp == 1));
    checkOutput("dm_ready", 32'(dm_ready_o), 32'(mResp == 2));
    checkOutput("if_data", if_data_o, mIfData);
    checkOutput("dm_rdata", dm_rdata_o, mDmData);
    checkOutput("err", 32'(err_o), 32'(mErr));

    if (ifDrop) begin
      ifPend = 0;
      ifDrop = 0;
    end
    started = 0;
    if (!ifPend && autoReq && ($urandom_range(99, 0) < reqRate)) begin
      ifPend  = 1;
      ifAddr  = $urandom;
      started = 1;
    end
    if (ifPend && !started && if_ready_o) ifDrop = 1;

    if (dmDrop) begin
      dmPend = 0;
      dmDrop = 0;
    end
    started = 0;
    if (!dmPend && autoReq && ($urandom_range(99, 0) < reqRate)) begin
      op      = $urandom_range(2, 0);
      dmPend  = 1;
      dmRd    = (op != 1);
      dmWr    = (op != 0);
      dmAddr  = $urandom;
      dmWdata = $urandom;
      started = 1;
    end
    if (dmPend && !started && dm_ready_o) dmDrop = 1;

    ack = 0;
    rd  = $urandom;
    if (forceData) rd = forcedData;
    if (forceAckOnce) begin
      ack = 1;
      forceAckOnce = 0;
    end else if (mOwner != 0) begin
      if (!noAck) begin
        if (memCnt == 0) ack = 1;
        else memCnt--;
      end
    end else if (spurious && ($urandom_range(9, 0) == 0)) begin
      ack = 1;
    end

    if_req_i    = ifPend;
    if_addr_i   = ifAddr;
    dm_read_i   = dmPend && dmRd;
    dm_write_i  = dmPend && dmWr;
    dm_addr_i   = dmAddr;
    dm_wdata_i  = dmWdata;
    mem_ack_i   = ack;
    mem_rdata_i = rd;

    #1;
    checkOutput("stall", 32'(stall_o), 32'((ifPend && mResp != 1) || (dmPend && mResp != 2)));

    newResp = 0;
    if (mOwner != 0) begin
      if (ack) begin
        if (mOwner == 1) mIfData = rd;
        else mDmData = rd;
        newResp = mOwner;
        mLast   = mOwner;
        mOwner  = 0;
      end else if (mCnt == TIMEOUT - 1) begin
        if (mOwner == 1) mIfData = '0;
        else mDmData = '0;
        mErr    = 1'b1;
        newResp = mOwner;
        mOwner  = 0;
      end else begin
        mCnt++;
      end
    end else begin
      eIf  = ifPend && (mResp != 1);
      eDm  = dmPend && (mResp != 2);
      pick = 0;
      if (eIf && eDm) pick = (mLast == 1) ? 2 : 1;
      else if (eIf) pick = 1;
      else if (eDm) pick = 2;
      if (pick == 1) begin
        mAddr = ifAddr;
        mWe   = 1'b0;
      end else if (pick == 2) begin
        mAddr  = dmAddr;
        mWe    = dmWr;
        mWdata = dmWdata;
      end
      if (pick != 0) begin
        mOwner = pick;
        mCnt   = 0;
        memCnt = $urandom_range(dlyHi, dlyLo);
      end
    end
    mResp = newResp;
  endtask

  // Hold reset for two cycles, check every output is cleared, then release.
  task automatic resetDut();
    rst_i      = 1'b0;
    ifPend     = 0;
    ifDrop     = 0;
    dmPend     = 0;
    dmDrop     = 0;
    if_req_i   = 1'b0;
    dm_read_i  = 1'b0;
    dm_write_i = 1'b0;
    mem_ack_i  = 1'b0;
    modelReset();
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_mem_req", 32'(mem_req_o), 0);
    checkOutput("rst_mem_we", 32'(mem_we_o), 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 0);
    checkOutput("rst_if_data", if_data_o, 0);
    checkOutput("rst_dm_rdata", dm_rdata_o, 0);
    checkOutput("rst_if_ready", 32'(if_ready_o), 0);
    checkOutput("rst_dm_ready", 32'(dm_ready_o), 0);
    checkOutput("rst_err", 32'(err_o), 0);
    checkOutput("rst_stall", 32'(stall_o), 0);
    rst_i = 1'b1;
  endtask

  int pulses;
  int prevPort;
  int port;
  int reqCycles;
  int readies;

  initial begin
    modelReset();
    resetDut();

    // Single fetch with an ack in the first busy cycle.
    forceData  = 1;
    forcedData = 32'h0050_0093;
    ifPend     = 1;
    ifAddr     = 32'h0000_0010;
    applyStimulus();
    checkOutput("fetch_c0_req", 32'(mem_req_o), 0);
    checkOutput("fetch_c0_stall", 32'(stall_o), 1);
    applyStimulus();
    checkOutput("fetch_c1_req", 32'(mem_req_o), 1);
    checkOutput("fetch_c1_we", 32'(mem_we_o), 0);
    checkOutput("fetch_c1_addr", mem_addr_o, 32'h0000_0010);
    checkOutput("fetch_c1_stall", 32'(stall_o), 1);
    applyStimulus();
    checkOutput("fetch_c2_ready", 32'(if_ready_o), 1);
    checkOutput("fetch_c2_data", if_data_o, 32'h0050_0093);
    checkOutput("fetch_c2_stall", 32'(stall_o), 0);
    repeat (2) applyStimulus();

    // Simultaneous fetch and read right after reset: DM first, then IF.
    resetDut();
    forceData = 0;
    ifPend    = 1;
    ifAddr    = 32'h0000_0020;
    dmPend    = 1;
    dmRd      = 1;
    dmWr      = 0;
    dmAddr    = 32'h0000_0100;
    applyStimulus();
    applyStimulus();
    checkOutput("both_first_addr", mem_addr_o, 32'h0000_0100);
    applyStimulus();
    checkOutput("both_dm_ready", 32'(dm_ready_o), 1);
    checkOutput("both_if_ready", 32'(if_ready_o), 0);
    applyStimulus();
    checkOutput("both_second_req", 32'(mem_req_o), 1);
    checkOutput("both_second_addr", mem_addr_o, 32'h0000_0020);
    repeat (3) applyStimulus();

    // Write with a slow memory.
    dmPend  = 1;
    dmRd    = 0;
    dmWr    = 1;
    dmAddr  = 32'h0000_0008;
    dmWdata = 32'hCAFE_F00D;
    dlyLo   = 5;
    dlyHi   = 5;
    pulses  = 0;
    repeat (10) begin
      applyStimulus();
      if (mem_req_o) begin
        checkOutput("write_we", 32'(mem_we_o), 1);
        checkOutput("write_wdata", mem_wdata_o, 32'hCAFE_F00D);
      end
      if (dm_ready_o) pulses++;
    end
    checkOutput("write_pulses", pulses, 1);

    // Both ports requesting continuously: completions must alternate.
    autoReq  = 1;
    reqRate  = 100;
    dlyLo    = 0;
    dlyHi    = 0;
    prevPort = 0;
    repeat (40) begin
      applyStimulus();
      if (if_ready_o || dm_ready_o) begin
        port = if_ready_o ? 1 : 2;
        if (prevPort != 0) checkOutput("alternate_port", port, 3 - prevPort);
        prevPort = port;
      end
    end
    autoReq = 0;
    repeat (8) applyStimulus();

    // Random traffic with variable latency and stray acks.
    autoReq  = 1;
    reqRate  = 35;
    dlyLo    = 0;
    dlyHi    = 4;
    spurious = 1;
    repeat (1500) applyStimulus();
    autoReq  = 0;
    spurious = 0;
    repeat (25) applyStimulus();

    // Fetch that never gets an ack.
    noAck     = 1;
    ifPend    = 1;
    ifAddr    = $urandom;
    reqCycles = 0;
    readies   = 0;
    repeat (70) begin
      applyStimulus();
      if (mem_req_o) reqCycles++;
      if (if_ready_o) begin
        readies++;
        checkOutput("timeout_data", if_data_o, 0);
      end
    end
    checkOutput("timeout_busy_cycles", reqCycles, TIMEOUT);
    checkOutput("timeout_ready_pulses", readies, 1);
    checkOutput("timeout_err", 32'(err_o), 1);
    repeat (3) applyStimulus();
    checkOutput("err_sticky", 32'(err_o), 1);

    // Reset in the middle of a data access, then a late ack.
    dmPend = 1;
    dmRd   = 1;
    dmWr   = 0;
    dmAddr = $urandom;
    repeat (3) applyStimulus();
    checkOutput("busy_before_reset", 32'(mem_req_o), 1);
    #1;
    rst_i = 1'b0;
    #1;
    checkOutput("reset_memreq_async", 32'(mem_req_o), 0);
    checkOutput("reset_dm_ready", 32'(dm_ready_o), 0);
    checkOutput("reset_err", 32'(err_o), 0);
    resetDut();
    noAck        = 0;
    forceAckOnce = 1;
    repeat (3) begin
      applyStimulus();
      checkOutput("late_ack_memreq", 32'(mem_req_o), 0);
      checkOutput("late_ack_dm_ready", 32'(dm_ready_o), 0);
      checkOutput("late_ack_err", 32'(err_o), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
